// File: rtl/mod_multiplier_serial.sv
// Bit-serial interleaved (A*B) mod Q, MSB first; MOD_MULT_INPUT_REDUCE_EN adds a one-cycle operand pre-reduction.
// Latency BITWIDTH cycles (+1 with reduction); result held in DONE until iReady, oReady only in IDLE.
module mod_multiplier_serial #(
  parameter int BITWIDTH = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic [BITWIDTH-1:0] iQ,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData
);

  localparam int CW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

`ifdef MOD_MULT_INPUT_REDUCE_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_REDUCE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;

  // One interleaved step; intermediates carry an extra bit so 2R and T+A never wrap.
  logic [BITWIDTH:0]   t2, u1;
  logic [BITWIDTH-1:0] t, u;

  always_comb begin
    t2 = {r_q, 1'b0};
    t  = (t2 >= {1'b0, q_q}) ? BITWIDTH'(t2 - {1'b0, q_q}) : t2[BITWIDTH-1:0];
    u1 = {1'b0, t} + {1'b0, a_q};
    if (b_q[cnt_q]) begin
      u = (u1 >= {1'b0, q_q}) ? BITWIDTH'(u1 - {1'b0, q_q}) : u1[BITWIDTH-1:0];
    end else begin
      u = t;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          a_d   = iA;
          b_d   = iB;
          q_d   = iQ;
          r_d   = '0;
          cnt_d = CW'(BITWIDTH - 1);
`ifdef MOD_MULT_INPUT_REDUCE_EN
          state_d = S_REDUCE;
`else
          state_d = S_CALC;
`endif
        end
      end
`ifdef MOD_MULT_INPUT_REDUCE_EN
      S_REDUCE: begin
        a_d     = (a_q >= q_q) ? a_q - q_q : a_q;
        b_d     = (b_q >= q_q) ? b_q - q_q : b_q;
        state_d = S_CALC;
      end
`endif
      S_CALC: begin
        r_d = u;
        if (cnt_q == '0) begin
          data_d  = u;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort discards everything, including an undelivered result.
    if (iClr) begin
      state_d = S_IDLE;
      a_d     = '0;
      b_d     = '0;
      q_d     = '0;
      r_d     = '0;
      cnt_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oReady = (state_q == S_IDLE);
  assign oValid = valid_q;
  assign oData  = data_q;

`ifndef SYNTHESIS
  always_ff @(posedge iClk) begin
    if (!iRst && !iClr && iValid && oReady) begin
`ifdef MOD_MULT_INPUT_REDUCE_EN
      assert (iQ != '0 && {1'b0, iA} < {iQ, 1'b0} && {1'b0, iB} < {iQ, 1'b0})
        else $error("operand out of range for modulus");
`else
      assert (iQ != '0 && iA < iQ && iB < iQ)
        else $error("operand out of range for modulus");
`endif
    end
  end
`endif

endmodule
